// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states and default widths.
// Latency: n/a; backpressure: n/a.
package rv32_pipe_pkg;

  localparam int unsigned num_width_def = 5;
  localparam int unsigned cnt_width_def = 32;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter; holds at all-ones and never wraps.
// Latency: count visible the cycle after inc; backpressure: none.
module sat_counter #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] cnt
);

  localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {width{1'b1}})) cnt_d = cnt_q + one;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, branch flushes, memory-wait freezes.
// Latency: control outputs are zero-latency combinational; counters lag one cycle.
module hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned num_width = num_width_def,
  parameter int unsigned cnt_width = cnt_width_def
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [num_width-1:0] id_rd_num1,
  input  logic [num_width-1:0] id_rd_num2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_memory_rd,
  input  logic [num_width-1:0] ex_wr_num,
  input  logic                 ex_branch_taken,
  input  logic                 mem_busy,
  output logic                 pc_hold,
  output logic                 ifid_hold,
  output logic                 idex_hold,
  output logic                 exmem_hold,
  output logic                 ifid_flush,
  output logic                 flush,
  output logic                 rd_after_ld,
  output logic [cnt_width-1:0] stall_cnt,
  output logic [cnt_width-1:0] flush_cnt
);

  hz_state_e state_q, state_d;
  logic      pend_br_q, pend_br_d;
  logic      ld_haz, br_eff;

  always_comb begin
    ld_haz = ex_memory_rd && (ex_wr_num != '0) &&
             ((id_uses_rs1 && (id_rd_num1 == ex_wr_num)) ||
              (id_uses_rs2 && (id_rd_num2 == ex_wr_num)));
    br_eff = ex_branch_taken || (pend_br_q && (state_q == MEM_WAIT));
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    ifid_flush  = 1'b0;
    flush       = 1'b0;
    rd_after_ld = 1'b0;
    state_d     = state_q;
    pend_br_d   = pend_br_q;

    if (mem_busy) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      state_d    = MEM_WAIT;
      // A taken branch seen while frozen must still redirect once memory frees up.
      pend_br_d  = (state_q == MEM_WAIT) ? (pend_br_q || ex_branch_taken) : ex_branch_taken;
    end else begin
      if (br_eff) begin
        flush      = 1'b1;
        ifid_flush = 1'b1;
      end else if (ld_haz) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        rd_after_ld = 1'b1;
      end
      state_d   = RUN;
      pend_br_d = 1'b0;
    end

    if (rst) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      idex_hold   = 1'b0;
      exmem_hold  = 1'b0;
      ifid_flush  = 1'b0;
      flush       = 1'b0;
      rd_after_ld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pend_br_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_br_q <= pend_br_d;
    end
  end

  sat_counter #(.width(cnt_width)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_hold || rd_after_ld),
    .cnt (stall_cnt)
  );

  sat_counter #(.width(cnt_width)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a rule-level model checks every cycle, literals pin key scenarios.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rd_num1, id_rd_num2, ex_wr_num;
  logic       id_uses_rs1, id_uses_rs2, ex_memory_rd, ex_branch_taken, mem_busy;

  logic        pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, flush, rd_after_ld;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_pc_hold, s_ifid_hold, s_idex_hold, s_exmem_hold, s_ifid_flush, s_flush, s_rd_after_ld;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rd_num1(id_rd_num1), .id_rd_num2(id_rd_num2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memory_rd(ex_memory_rd), .ex_wr_num(ex_wr_num),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .ifid_flush(ifid_flush), .flush(flush), .rd_after_ld(rd_after_ld),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.num_width(5), .cnt_width(4)) dut_small (
    .clk(clk), .rst(rst),
    .id_rd_num1(id_rd_num1), .id_rd_num2(id_rd_num2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memory_rd(ex_memory_rd), .ex_wr_num(ex_wr_num),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .idex_hold(s_idex_hold), .exmem_hold(s_exmem_hold),
    .ifid_flush(s_ifid_flush), .flush(s_flush), .rd_after_ld(s_rd_after_ld),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: "frozen" = currently waiting on memory, "owed" = a taken branch seen while frozen.
  bit    frozen = 1'b0;
  bit    owed   = 1'b0;
  longint stalls = 0;
  longint flushes = 0;

  always @(negedge clk) begin
    if (model_on) begin
      bit e_pc, e_ifid, e_idex, e_exmem, e_iflush, e_flush, e_bubble, load_use, redirect;
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_iflush = 0; e_flush = 0; e_bubble = 0;
      load_use = ex_memory_rd && (ex_wr_num != 0) &&
                 ((id_uses_rs1 && id_rd_num1 == ex_wr_num) || (id_uses_rs2 && id_rd_num2 == ex_wr_num));
      redirect = ex_branch_taken || (frozen && owed);
      if (!rst) begin
        if (mem_busy)      {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
        else if (redirect) {e_flush, e_iflush} = 2'b11;
        else if (load_use) {e_pc, e_ifid, e_bubble} = 3'b111;
      end
      chk("pc_hold", pc_hold, e_pc);
      chk("ifid_hold", ifid_hold, e_ifid);
      chk("idex_hold", idex_hold, e_idex);
      chk("exmem_hold", exmem_hold, e_exmem);
      chk("ifid_flush", ifid_flush, e_iflush);
      chk("flush", flush, e_flush);
      chk("rd_after_ld", rd_after_ld, e_bubble);
      chk("stall_cnt", stall_cnt, stalls);
      chk("flush_cnt", flush_cnt, flushes);
      chk("small_stall_cnt", s_stall_cnt, (stalls > 15) ? 15 : stalls);
      chk("small_flush_cnt", s_flush_cnt, (flushes > 15) ? 15 : flushes);
      if (rst) begin
        frozen = 0; owed = 0; stalls = 0; flushes = 0;
      end else begin
        if (e_pc || e_bubble) stalls++;
        if (e_flush) flushes++;
        if (mem_busy) begin
          owed   = frozen ? (owed || ex_branch_taken) : ex_branch_taken;
          frozen = 1;
        end else begin
          frozen = 0;
          owed   = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rd_num1 = 0; id_rd_num2 = 0; ex_wr_num = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memory_rd = 0;
    ex_branch_taken = 0; mem_busy = 0;
  endtask

  task automatic load_use_rs1(input logic [4:0] r);
    ex_memory_rd = 1; ex_wr_num = r; id_rd_num1 = r; id_uses_rs1 = 1;
  endtask

  initial begin
    idle();
    rst = 1; mem_busy = 1;
    cyc();
    model_on = 1;
    @(negedge clk);
    chk("lit_rst_pc_hold", pc_hold, 0);
    chk("lit_rst_exmem_hold", exmem_hold, 0);

    cyc(); rst = 0; idle();
    @(negedge clk);
    chk("lit_rst_stall_cnt", stall_cnt, 0);
    chk("lit_rst_flush_cnt", flush_cnt, 0);

    // load-use on rs1
    cyc(); load_use_rs1(5);
    @(negedge clk);
    chk("lit_lu_rd_after_ld", rd_after_ld, 1);
    chk("lit_lu_pc_hold", pc_hold, 1);
    chk("lit_lu_ifid_hold", ifid_hold, 1);
    chk("lit_lu_idex_hold", idex_hold, 0);
    cyc(); idle();
    @(negedge clk);
    chk("lit_lu_stall_cnt", stall_cnt, 1);

    // x0 destination and unused source never stall
    cyc(); ex_memory_rd = 1; ex_wr_num = 0; id_rd_num1 = 0; id_uses_rs1 = 1;
    @(negedge clk);
    chk("lit_x0_pc_hold", pc_hold, 0);
    cyc(); idle(); ex_memory_rd = 1; ex_wr_num = 7; id_rd_num2 = 7; id_uses_rs2 = 0;
    @(negedge clk);
    chk("lit_unused_rd_after_ld", rd_after_ld, 0);
    cyc(); id_uses_rs2 = 1;
    @(negedge clk);
    chk("lit_rs2_rd_after_ld", rd_after_ld, 1);

    // taken branch beats load-use
    cyc(); idle(); load_use_rs1(9); ex_branch_taken = 1;
    @(negedge clk);
    chk("lit_br_flush", flush, 1);
    chk("lit_br_ifid_flush", ifid_flush, 1);
    chk("lit_br_rd_after_ld", rd_after_ld, 0);
    cyc(); idle();
    @(negedge clk);
    chk("lit_br_flush_cnt", flush_cnt, 1);
    chk("lit_br_stall_cnt", stall_cnt, 2);

    // three-cycle memory wait with a branch pulse in the middle
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); mem_busy = 1; ex_branch_taken = (i == 1);
      @(negedge clk);
      chk("lit_mw_all_holds", {pc_hold, ifid_hold, idex_hold, exmem_hold}, 4'hF);
      chk("lit_mw_flush", flush, 0);
    end
    cyc(); idle();
    @(negedge clk);
    chk("lit_mw_exit_flush", flush, 1);
    chk("lit_mw_exit_pc_hold", pc_hold, 0);
    cyc(); idle();
    @(negedge clk);
    chk("lit_mw_stall_cnt", stall_cnt, 5);
    chk("lit_mw_flush_cnt", flush_cnt, 2);

    // load-use on the wait-exit cycle is handled immediately
    cyc(); mem_busy = 1;
    cyc(); idle(); load_use_rs1(3);
    @(negedge clk);
    chk("lit_exit_lu_rd_after_ld", rd_after_ld, 1);
    cyc(); idle();
    @(negedge clk);
    chk("lit_exit_lu_stall_cnt", stall_cnt, 7);

    // reset in the middle of a wait discards the owed branch
    cyc(); mem_busy = 1; ex_branch_taken = 1;
    cyc(); ex_branch_taken = 0; rst = 1;
    @(negedge clk);
    chk("lit_rstw_pc_hold", pc_hold, 0);
    chk("lit_rstw_idex_hold", idex_hold, 0);
    cyc(); rst = 0; idle();
    @(negedge clk);
    chk("lit_rstw_flush", flush, 0);
    chk("lit_rstw_stall_cnt", stall_cnt, 0);
    chk("lit_rstw_flush_cnt", flush_cnt, 0);

    // 17 stall cycles: 4-bit instance pins at 15
    for (int i = 0; i < 17; i++) begin
      cyc(); idle(); load_use_rs1(5'(i % 31 + 1));
    end
    cyc(); idle();
    @(negedge clk);
    chk("lit_sat_small", s_stall_cnt, 4'hF);
    chk("lit_sat_main", stall_cnt, 17);

    cyc(); cyc();
    model_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
